// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbitrated Q/nQ register.
// Default N/W, FSM state encoding and search-order index helpers.
package dff_reg_arbiter_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // k-th requester examined when the rotating pointer sits at ptr
  function automatic int search_idx(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo N; returns a one-hot winner and a valid flag.
module dff_reg_arbiter_rr_pick
  import dff_reg_arbiter_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic          valid_o
);

  logic          found;
  logic [PW-1:0] idx;

  // NOTE: every variable written here gets a default before any branch,
  // otherwise the unassigned paths would infer latches.
  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'(search_idx(int'(ptr_i), k, N));
      if (!found && req_i[idx]) begin
        onehot_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin write controller for one shared W-bit Q/nQ register.
// Define ARB_LOCK_EN to let a holder keep ownership for back-to-back writes.
module dff_reg_arbiter
  import dff_reg_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           CK,
  input  logic           Cr,
  input  logic           clr,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   nQ,
  output logic           busy
);

  localparam int PW = ptr_width(N);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] hold_q, hold_d;
  logic [PW-1:0] hold_next, pick_idx;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  pick_oh;
  logic          pick_valid;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  wd [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign wd[i] = wdata[i*W +: W];
  end

  dff_reg_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .valid_o  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_oh[i]) pick_idx = PW'(i);
    end
  end

  assign hold_next = PW'(wrap_inc(int'(hold_q), N));

`ifdef ARB_LOCK_EN
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = '0;
    ack_d   = '0;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_oh;
          hold_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT, LOCKED: begin
        state_d = IDLE;
        if (req[hold_q]) begin
          q_d           = wd[hold_q];
          ack_d[hold_q] = 1'b1;
`ifdef ARB_LOCK_EN
          if (lock[hold_q]) begin
            gnt_d   = gnt_q;
            state_d = LOCKED;
          end else begin
            ptr_d = hold_next;
          end
`else
          ptr_d = hold_next;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear beats any write landing on the same edge; the pointer stays put.
    if (clr) begin
      state_d = IDLE;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      ack_d   = '0;
      q_d     = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge CK) begin
    if (Cr) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign Q    = q_q;
  assign nQ   = ~q_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed vector bench for dff_reg_arbiter (N=4, W=8); the lock sequence
// follows whichever build of ARB_LOCK_EN is compiled.
module tb_dff_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         CK = 1'b0;
  logic         Cr = 1'b1;
  logic         clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0] gnt, ack;
  logic [W-1:0] Q, nQ;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  dff_reg_arbiter #(.N(N), .W(W)) dut (
    .CK    (CK),
    .Cr    (Cr),
    .clr   (clr),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .Q     (Q),
    .nQ    (nQ),
    .busy  (busy)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic        cr;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step(input logic cr_v, input logic clr_v, input logic [3:0] req_v,
                      input logic [3:0] lock_v, input logic [31:0] wd_v);
    Cr    = cr_v;
    clr   = clr_v;
    req   = req_v;
    lock  = lock_v;
    wdata = wd_v;
    @(posedge CK);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                            input logic [7:0] e_q, input logic e_busy);
    logic [7:0] e_nq;
    e_nq = ~e_q;
    check({name, ".gnt"},  {28'h0, gnt},  {28'h0, e_gnt});
    check({name, ".ack"},  {28'h0, ack},  {28'h0, e_ack});
    check({name, ".Q"},    {24'h0, Q},    {24'h0, e_q});
    check({name, ".nQ"},   {24'h0, nQ},   {24'h0, e_nq});
    check({name, ".busy"}, {31'h0, busy}, {31'h0, e_busy});
  endtask

  initial begin
    //                        cr    clr   req      wdata         gnt      ack      Q      busy
    vecs.push_back(vec_t'{1'b1, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 1'b0, "rst0"});
    vecs.push_back(vec_t'{1'b1, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 1'b0, "rst1"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 1'b0, "idle"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0001, 32'h000000A5, 4'b0001, 4'b0000, 8'h00, 1'b1, "w0_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0001, 32'h000000A5, 4'b0000, 4'b0001, 8'hA5, 1'b0, "w0_ack"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 32'h000000A5, 4'b0000, 4'b0000, 8'hA5, 1'b0, "w0_done"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b0010, 4'b0000, 8'hA5, 1'b1, "rr1_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b0000, 4'b0010, 8'h11, 1'b0, "rr1_ack"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b0100, 4'b0000, 8'h11, 1'b1, "rr2_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b0000, 4'b0100, 8'h12, 1'b0, "rr2_ack"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b1000, 4'b0000, 8'h12, 1'b1, "rr3_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b0000, 4'b1000, 8'h13, 1'b0, "rr3_ack"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b0001, 4'b0000, 8'h13, 1'b1, "rr0_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1111, 32'h13121110, 4'b0000, 4'b0001, 8'h10, 1'b0, "rr0_ack"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0100, 32'h13121110, 4'b0100, 4'b0000, 8'h10, 1'b1, "ab_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 32'h13121110, 4'b0000, 4'b0000, 8'h10, 1'b0, "ab_drop"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1100, 32'h13121110, 4'b0100, 4'b0000, 8'h10, 1'b1, "ab_regnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1100, 32'h13121110, 4'b0000, 4'b0100, 8'h12, 1'b0, "ab_wr"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1000, 32'h3C000000, 4'b1000, 4'b0000, 8'h12, 1'b1, "c_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b1000, 32'h3C000000, 4'b0000, 4'b1000, 8'h3C, 1'b0, "c_wr3c"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0001, 32'h00000077, 4'b0001, 4'b0000, 8'h3C, 1'b1, "c_gnt77"});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 32'h00000077, 4'b0000, 4'b0000, 8'h00, 1'b0, "c_clr"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0001, 32'h00000077, 4'b0001, 4'b0000, 8'h00, 1'b1, "r_gnt"});
    vecs.push_back(vec_t'{1'b1, 1'b0, 4'b0001, 32'h00000077, 4'b0000, 4'b0000, 8'h00, 1'b0, "r_midgnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 32'h00000077, 4'b0000, 4'b0000, 8'h00, 1'b0, "r_after"});
    vecs.push_back(vec_t'{1'b0, 1'b1, 4'b1111, 32'h00000077, 4'b0000, 4'b0000, 8'h00, 1'b0, "clr_idle"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0010, 32'h00005A00, 4'b0010, 4'b0000, 8'h00, 1'b1, "p_gnt"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0010, 32'h00005A00, 4'b0000, 4'b0010, 8'h5A, 1'b0, "p_wr"});
    vecs.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 32'h00005A00, 4'b0000, 4'b0000, 8'h5A, 1'b0, "p_idle"});

    foreach (vecs[i]) begin
      step(vecs[i].cr, vecs[i].clr, vecs[i].req, 4'b0000, vecs[i].wdata);
      expect_out(vecs[i].name, vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].busy);
    end

    // Pointer now sits at 2, so requester 3 wins first.
    step(1'b0, 1'b0, 4'b1000, 4'b1000, 32'h40000000);
    expect_out("lk_gnt", 4'b1000, 4'b0000, 8'h5A, 1'b1);
    step(1'b0, 1'b0, 4'b1000, 4'b1000, 32'h40000000);
`ifdef ARB_LOCK_EN
    expect_out("lk_w40", 4'b1000, 4'b1000, 8'h40, 1'b1);
    for (int k = 1; k < 4; k++) begin
      step(1'b0, 1'b0, 4'b1000, 4'b1000, {8'(8'h40 + k), 24'h0});
      expect_out($sformatf("lk_w%0h", 8'h40 + k), 4'b1000, 4'b1000, 8'(8'h40 + k), 1'b1);
    end
    step(1'b0, 1'b0, 4'b1000, 4'b0000, 32'h44000000);
    expect_out("lk_final", 4'b0000, 4'b1000, 8'h44, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 4'b0000, 32'h44000000);
    expect_out("lk_ptr0", 4'b0001, 4'b0000, 8'h44, 1'b1);
`else
    expect_out("nolk_w40", 4'b0000, 4'b1000, 8'h40, 1'b0);
    step(1'b0, 1'b0, 4'b1000, 4'b1000, 32'h41000000);
    expect_out("nolk_gnt", 4'b1000, 4'b0000, 8'h40, 1'b1);
    step(1'b0, 1'b0, 4'b1000, 4'b1000, 32'h41000000);
    expect_out("nolk_w41", 4'b0000, 4'b1000, 8'h41, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 4'b0000, 32'h41000000);
    expect_out("nolk_ptr0", 4'b0001, 4'b0000, 8'h41, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
